// File: rtl/usb_rst_pkg.sv
// Shared types and constants for the USB reset sequencer.
// Holds the state encoding, register word addresses and status bit positions.
package usb_rst_pkg;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StRecover = 2'd1,
        StReady   = 2'd2
    } usb_rst_state_e;

    localparam logic [1:0] AddrStatus = 2'd0;
    localparam logic [1:0] AddrCnt    = 2'd1;
    localparam logic [1:0] AddrClr    = 2'd2;

    localparam int unsigned StatusReadyBit = 0;
    localparam int unsigned StatusRstBit   = 1;
    localparam int unsigned StatusStateLsb = 2;
    localparam int unsigned StatusCountLsb = 8;

endpackage

// File: rtl/usb_rst_timer.sv
// Cycle counter for the reset sequencer: clear, enable, and a limit that
// both saturates the count and drives the terminal-compare output.
module usb_rst_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q < limit)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q >= limit);

endmodule

// File: rtl/usb_rst_sequencer.sv
// Drives the MAX3421E reset pin with a minimum low width and a recovery window,
// and exposes status and a clearable release counter over Avalon-MM.
module usb_rst_sequencer
    import usb_rst_pkg::*;
#(
    parameter int unsigned ASSERT_CYCLES  = 500,
    parameter int unsigned RECOVER_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rst_req,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        usb_rst_n,
    output logic        usb_ready
);

    localparam logic [CNT_W-1:0] AssertLast  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RecoverLast = CNT_W'(RECOVER_CYCLES - 1);

    usb_rst_state_e   state_q, state_d;
    logic             usb_rst_n_d, usb_ready_d;
    logic [7:0]       reset_count_q, reset_count_d;
    logic [CNT_W-1:0] cnt, limit;
    logic             done, timer_clr, timer_en, released, clr_wr;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;

    assign limit     = (state_q == StAssert) ? AssertLast : RecoverLast;
    assign timer_en  = (state_q != StReady);
    assign timer_clr = (state_d != state_q) || (state_q == StReady);

    usb_rst_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .limit (limit),
        .cnt   (cnt),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StAssert;
            usb_rst_n     <= 1'b0;
            usb_ready     <= 1'b0;
            reset_count_q <= '0;
        end else begin
            state_q       <= state_d;
            usb_rst_n     <= usb_rst_n_d;
            usb_ready     <= usb_ready_d;
            reset_count_q <= reset_count_d;
        end
    end

    // A new request during recovery wins over completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StAssert:  if (done && !rst_req) state_d = StRecover;
            StRecover: begin
                if (rst_req) begin
                    state_d = StAssert;
                end else if (done) begin
                    state_d = StReady;
                end
            end
            StReady:   if (rst_req) state_d = StAssert;
            default:   state_d = StAssert;
        endcase
    end

    always_comb begin
        usb_rst_n_d = (state_d != StAssert);
        usb_ready_d = (state_d == StReady);
    end

    assign released = (state_q == StAssert) && (state_d == StRecover);
    assign clr_wr   = chipselect && !write_n && (address == AddrClr);

    // A clear that lands on a release still counts that release.
    always_comb begin
        reset_count_d = reset_count_q;
        if (clr_wr) begin
            reset_count_d = {7'd0, released};
        end else if (released && (reset_count_q != 8'hff)) begin
            reset_count_d = reset_count_q + 8'd1;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                AddrStatus: begin
                    readdata[StatusReadyBit]      = usb_ready;
                    readdata[StatusRstBit]        = ~usb_rst_n;
                    readdata[StatusStateLsb +: 2] = state_q;
                    readdata[StatusCountLsb +: 8] = reset_count_q;
                end
                AddrCnt:    readdata = 32'(cnt);
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Bench for usb_rst_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a phase/elapsed model.
module tb_usb_rst_sequencer;

    localparam int A = 4;
    localparam int R = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rst_req = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        usb_rst_n;
    logic        usb_ready;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Model: phase 0=asserting, 1=recovering, 2=ready; elapsed cycles in phase.
    int m_phase = 0;
    int m_elapsed = 0;
    int m_rc = 0;

    usb_rst_sequencer #(
        .ASSERT_CYCLES  (A),
        .RECOVER_CYCLES (R),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rst_req    (rst_req),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .usb_rst_n  (usb_rst_n),
        .usb_ready  (usb_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
        if (m_phase == 0) return (m_elapsed < A - 1) ? m_elapsed : A - 1;
        if (m_phase == 1) return m_elapsed;
        return 0;
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] v;
        v = 32'd0;
        if (chipselect) begin
            if (address == 2'd0) begin
                v = (m_phase == 2 ? 32'd1 : 32'd0) + (m_phase == 0 ? 32'd2 : 32'd0)
                    + 32'(m_phase) * 4 + 32'(m_rc) * 256;
            end else if (address == 2'd1) begin
                v = 32'(exp_cnt());
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin : model
        int p, e, rc;
        bit rel, clr;
        p = m_phase;
        e = m_elapsed;
        rc = m_rc;
        rel = 1'b0;
        clr = chipselect && !write_n && (address == 2'd2);
        if (reset) begin
            p = 0; e = 0; rc = 0;
        end else begin
            if (p == 0) begin
                if (e >= A - 1 && !rst_req) begin p = 1; e = 0; rel = 1'b1; end
                else e = e + 1;
            end else if (p == 1) begin
                if (rst_req) begin p = 0; e = 0; end
                else if (e == R - 1) begin p = 2; e = 0; end
                else e = e + 1;
            end else if (rst_req) begin
                p = 0; e = 0;
            end
            if (clr) rc = rel ? 1 : 0;
            else if (rel && rc < 255) rc = rc + 1;
        end
        m_phase <= p;
        m_elapsed <= e;
        m_rc <= rc;
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("usb_rst_n", 32'(usb_rst_n), (m_phase != 0) ? 32'd1 : 32'd0);
            chk("usb_ready", 32'(usb_ready), (m_phase == 2) ? 32'd1 : 32'd0);
            chk("readdata", readdata, exp_read());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        chipselect = 1'b1;
        address = a;
        #1 v = readdata;
        chipselect = 1'b0;
        address = 2'd0;
    endtask

    task automatic wr(input logic [1:0] a);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = a;
        writedata = $urandom;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
        address = 2'd0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!usb_ready && n < 200) begin n++; tick(); end
        if (!usb_ready) chk(name, 32'(usb_ready), 32'd1);
    endtask

    task automatic wait_rst_high(input string name);
        int n;
        n = 0;
        while (!usb_rst_n && n < 200) begin n++; tick(); end
        if (!usb_rst_n) chk(name, 32'(usb_rst_n), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int lows, notready;
        bit ready_seen;

        // 1: power-up sequence
        tick();
        checking = 1'b1;
        tick();
        reset = 1'b0;
        lows = 0;
        while (!usb_rst_n && lows < 100) begin lows++; tick(); end
        chk("t1_low_cycles", 32'(lows), 32'd4);
        notready = 0;
        while (!usb_ready && notready < 100) begin notready++; tick(); end
        chk("t1_recover_cycles", 32'(notready), 32'd6);
        rd(2'd0, v);
        chk("t1_status", v, 32'h0000_0109);

        // 2: one-cycle request still yields full assertion
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        lows = 0;
        notready = 0;
        while (!usb_ready && notready < 100) begin
            notready++;
            if (!usb_rst_n) lows++;
            tick();
        end
        chk("t2_low_cycles", 32'(lows), 32'd4);
        chk("t2_notready_cycles", 32'(notready), 32'd10);
        rd(2'd0, v);
        chk("t2_reset_count", 32'(v[15:8]), 32'd2);

        // 3: held request stretches the low time
        rst_req = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!usb_rst_n) lows++;
            if (i == 10) begin
                rd(2'd1, v);
                chk("t3_cnt_saturated", v, 32'd3);
            end
        end
        rst_req = 1'b0;
        chk("t3_low_cycles", 32'(lows), 32'd20);
        tick();
        chk("t3_recover_after_fall", 32'(usb_rst_n), 32'd1);
        wait_ready("t3_ready_timeout");

        // 4: request during recovery aborts it
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        wait_rst_high("t4_recover_timeout");
        ready_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (usb_ready) ready_seen = 1'b1;
        end
        rd(2'd1, v);
        chk("t4_cnt_before_abort", v, 32'd3);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        chk("t4_rst_low_again", 32'(usb_rst_n), 32'd0);
        rd(2'd1, v);
        chk("t4_cnt_restart", v, 32'd0);
        chk("t4_ready_never", 32'(ready_seen || usb_ready), 32'd0);
        wait_ready("t4_ready_timeout");

        // 5: clear racing a release, plain clear, and a write elsewhere
        rd(2'd0, v);
        chk("t5_count_before", 32'(v[15:8]), 32'd5);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick();
        tick();
        tick();
        wr(2'd2);
        chk("t5_in_recover", 32'(usb_rst_n), 32'd1);
        rd(2'd0, v);
        chk("t5_clear_on_release", 32'(v[15:8]), 32'd1);
        wr(2'd0);
        rd(2'd0, v);
        chk("t5_write_addr0_ignored", 32'(v[15:8]), 32'd1);
        wr(2'd2);
        rd(2'd0, v);
        chk("t5_plain_clear", 32'(v[15:8]), 32'd0);
        wait_ready("t5_ready_timeout");

        // 6: reset during recovery
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        wait_rst_high("t6_recover_timeout");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_n", 32'(usb_rst_n), 32'd0);
        chk("t6_ready", 32'(usb_ready), 32'd0);
        rd(2'd0, v);
        chk("t6_status", v, 32'h0000_0002);
        lows = 0;
        while (!usb_rst_n && lows < 100) begin lows++; tick(); end
        chk("t6_low_cycles", 32'(lows), 32'd4);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(199) == 0);
            if (rst_req) rst_req = ($urandom_range(3) != 0);
            else rst_req = ($urandom_range(23) == 0);
            chipselect = $urandom_range(1);
            write_n = ($urandom_range(3) != 0);
            address = 2'($urandom_range(3));
            writedata = $urandom;
        end
        tick();
        reset = 1'b0;
        chipselect = 1'b0;
        write_n = 1'b1;
        tick();
        checking = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
